// File: rtl/utmi_rx_framer_pkg.sv
// Shared types and constants for the UTMI receive framer.
package usb_rx_pkg;

  localparam int unsigned DEF_FIFO_DEPTH = 8;

  // FIFO entry layout: {err, eop, sop, data[7:0]}
  localparam int unsigned ENTRY_W = 11;
  localparam int unsigned ERR_B   = 10;
  localparam int unsigned EOP_B   = 9;
  localparam int unsigned SOP_B   = 8;

  // Error terminator that closes an aborted packet.
  localparam logic [ENTRY_W-1:0] TERM_ENTRY = 11'h600;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_FIRST = 4'b0010,
    ST_HOLD  = 4'b0100,
    ST_DROP  = 4'b1000
  } rx_state_e;

  function automatic logic [ENTRY_W-1:0] mk_entry(input logic err, input logic eop,
                                                  input logic sop, input logic [7:0] data);
    return {err, eop, sop, data};
  endfunction

endpackage

// File: rtl/utmi_rx_framer_if.sv
// Byte stream from the framer towards the packet checkers.
interface rx_lp_if;
  logic       sop;
  logic       eop;
  logic       valid;
  logic [7:0] data;
  logic       err;
  logic       ready;

  modport master (output sop, eop, valid, data, err, input ready);
  modport slave  (input sop, eop, valid, data, err, output ready);
endinterface

// File: rtl/utmi_rx_framer_fifo.sv
// Synchronous show-ahead FIFO with count register and wrapping pointers.
module rx_lp_fifo #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  // A write at full is allowed when the head leaves in the same cycle.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/utmi_rx_framer.sv
// UTMI receive framer: turns RxActive/RxValid/RxError/DataOut into a
// sop/eop-delimited byte stream with backpressure via an elastic FIFO.
module utmi_rx_framer
  import usb_rx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       utmi_rx_active,
  input  logic       utmi_rx_valid,
  input  logic       utmi_rx_error,
  input  logic [7:0] utmi_data,
  rx_lp_if.master    rx_lp,
  output logic       ovf_pulse
);

  rx_state_e          state_q, state_d;
  logic [7:0]         hold_q, hold_d;
  logic               hold_sop_q, hold_sop_d;
  logic               pushed_q, pushed_d;
  logic               term_q, term_d;
  logic               ovf_q, ovf_d;

  logic               push_req;
  logic               term_push;
  logic [ENTRY_W-1:0] push_din;
  logic               can_push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [ENTRY_W-1:0] fifo_dout;

  assign pop      = rx_lp.valid && rx_lp.ready;
  assign can_push = !full || pop;

  rx_lp_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .pop   (pop),
    .din   (push_din),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  // Outputs are forced to zero when nothing is queued so reset shows all-zero.
  assign rx_lp.valid = !empty;
  assign rx_lp.data  = empty ? '0 : fifo_dout[7:0];
  assign rx_lp.sop   = !empty && fifo_dout[SOP_B];
  assign rx_lp.eop   = !empty && fifo_dout[EOP_B];
  assign rx_lp.err   = !empty && fifo_dout[ERR_B];
  assign ovf_pulse   = ovf_q;

  // State and holding-register update; a packet in flight at reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= utmi_rx_active ? ST_DROP : ST_IDLE;
      hold_q     <= '0;
      hold_sop_q <= 1'b0;
      pushed_q   <= 1'b0;
      term_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_sop_q <= hold_sop_d;
      pushed_q   <= pushed_d;
      term_q     <= term_d;
      ovf_q      <= ovf_d;
    end
  end

  // Next-state, push selection and overflow handling.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_sop_d = hold_sop_q;
    pushed_d   = pushed_q;
    term_d     = term_q;
    ovf_d      = 1'b0;
    push_req   = 1'b0;
    term_push  = 1'b0;
    push_din   = '0;

    unique case (state_q)
      ST_IDLE: begin
        pushed_d = 1'b0;
        if (term_q) begin
          push_req  = 1'b1;
          term_push = 1'b1;
          push_din  = TERM_ENTRY;
          if (can_push) term_d = 1'b0;
        end else if (utmi_rx_active) begin
          if (utmi_rx_error) begin
            state_d = ST_DROP;
          end else if (utmi_rx_valid) begin
            hold_d     = utmi_data;
            hold_sop_d = 1'b1;
            state_d    = ST_HOLD;
          end else begin
            state_d = ST_FIRST;
          end
        end
      end
      ST_FIRST: begin
        if (!utmi_rx_active) begin
          state_d = ST_IDLE;
        end else if (utmi_rx_error) begin
          if (pushed_q) begin
            push_req = 1'b1;
            push_din = TERM_ENTRY;
          end
          state_d = ST_DROP;
        end else if (utmi_rx_valid) begin
          hold_d     = utmi_data;
          hold_sop_d = !pushed_q;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        push_req = !utmi_rx_active || utmi_rx_error || utmi_rx_valid;
        if (!utmi_rx_active) begin
          push_din = mk_entry(1'b0, 1'b1, hold_sop_q, hold_q);
          state_d  = ST_IDLE;
        end else if (utmi_rx_error) begin
          push_din = mk_entry(1'b1, 1'b1, hold_sop_q, hold_q);
          state_d  = ST_DROP;
        end else if (utmi_rx_valid) begin
          push_din   = mk_entry(1'b0, 1'b0, hold_sop_q, hold_q);
          hold_d     = utmi_data;
          hold_sop_d = 1'b0;
        end
      end
      ST_DROP: begin
        if (term_q) begin
          push_req  = 1'b1;
          term_push = 1'b1;
          push_din  = TERM_ENTRY;
          if (can_push) term_d = 1'b0;
        end
        if (!utmi_rx_active) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A refused packet byte aborts the packet; the terminator is owed only
    // if the consumer has already seen part of it.
    if (push_req && !term_push) begin
      if (can_push) begin
        pushed_d = 1'b1;
      end else begin
        ovf_d   = 1'b1;
        term_d  = pushed_q;
        state_d = ST_DROP;
      end
    end
  end

endmodule

// File: tb/tb_utmi_rx_framer.sv
// Scoreboard bench for utmi_rx_framer: directed UTMI packets, expected
// beats queued by the stimulus, checked by an independent output monitor.
module tb_utmi_rx_framer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       act = 1'b0;
  logic       vld = 1'b0;
  logic       er = 1'b0;
  logic [7:0] dat = '0;
  logic       ovf_pulse;

  rx_lp_if rx_lp ();

  utmi_rx_framer #(.FIFO_DEPTH(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .utmi_rx_active (act),
    .utmi_rx_valid  (vld),
    .utmi_rx_error  (er),
    .utmi_data      (dat),
    .rx_lp          (rx_lp),
    .ovf_pulse      (ovf_pulse)
  );

  always #5 clk = ~clk;

  logic [10:0] exp_q [$];
  logic [10:0] mon_got;
  logic [10:0] mon_exp;
  int          n_vec = 0;
  int          n_bad = 0;
  int          ovf_cnt = 0;

  // Monitor: every accepted beat is compared with the head of the queue.
  always @(negedge clk) begin
    if (ovf_pulse === 1'b1) ovf_cnt++;
    if (rx_lp.valid === 1'b1 && rx_lp.ready === 1'b1) begin
      mon_got = {rx_lp.err, rx_lp.eop, rx_lp.sop, rx_lp.data};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL beat: got {err,eop,sop,data}=%h, required none (unexpected)", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_bad++;
          $display("FAIL beat: got {err,eop,sop,data}=%h, required %h", mon_got, mon_exp);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    n_vec++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, got, req);
    end
  endtask

  task automatic cyc(input logic a, input logic v, input logic e, input logic [7:0] d);
    act = a; vld = v; er = e; dat = d;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_beat(input logic [10:0] b);
    exp_q.push_back(b);
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || rx_lp.valid === 1'b1) && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(nm, exp_q.size(), 0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, {rx_lp.valid, rx_lp.sop, rx_lp.eop, rx_lp.err, rx_lp.data, ovf_pulse}, 0);
  endtask

  initial begin
    int ovf_base;
    logic [7:0] b;
    rx_lp.ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset_outputs");
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 8'h00);

    // Basic three-byte packet, with the last-byte latency check.
    expect_beat(11'h1A5); expect_beat(11'h012); expect_beat(11'h234);
    cyc(1, 1, 0, 8'hA5); cyc(1, 1, 0, 8'h12); cyc(1, 1, 0, 8'h34);
    cyc(0, 0, 0, 8'h00);
    chk("last_byte_latency", {rx_lp.valid, rx_lp.eop, rx_lp.data}, {22'h0, 2'b11, 8'h34});
    drain("drain_basic");

    // Bit-stuff gaps inside the packet.
    expect_beat(11'h1C3); expect_beat(11'h001); expect_beat(11'h002); expect_beat(11'h203);
    cyc(1, 1, 0, 8'hC3); cyc(1, 0, 0, 8'hEE); cyc(1, 1, 0, 8'h01); cyc(1, 0, 0, 8'hEE);
    cyc(1, 0, 0, 8'hEE); cyc(1, 1, 0, 8'h02); cyc(1, 1, 0, 8'h03); cyc(1, 0, 0, 8'hEE);
    cyc(0, 0, 0, 8'h00);
    drain("drain_gaps");

    // RxError after two bytes, trailing bytes dropped, next packet clean.
    expect_beat(11'h169); expect_beat(11'h681); expect_beat(11'h3D2);
    cyc(1, 1, 0, 8'h69); cyc(1, 1, 0, 8'h81); cyc(1, 0, 1, 8'h00);
    cyc(1, 1, 0, 8'hAA); cyc(1, 1, 0, 8'hBB); cyc(0, 0, 0, 8'h00);
    cyc(1, 1, 0, 8'hD2); cyc(0, 0, 0, 8'h00);
    drain("drain_error");

    // Zero-length packet, then two single-byte packets one idle cycle apart.
    cyc(1, 0, 0, 8'h00); cyc(1, 0, 0, 8'h00); cyc(1, 0, 0, 8'h00); cyc(0, 0, 0, 8'h00);
    expect_beat(11'h3D2); expect_beat(11'h35A);
    cyc(1, 1, 0, 8'hD2); cyc(0, 0, 0, 8'h00); cyc(1, 1, 0, 8'h5A); cyc(0, 0, 0, 8'h00);
    drain("drain_b2b");
    chk("no_ovf_yet", ovf_cnt, 0);

    // Overflow: 12 bytes into an 8-entry FIFO with the consumer stalled.
    rx_lp.ready = 1'b0;
    ovf_base = ovf_cnt;
    expect_beat(11'h140);
    for (int i = 1; i < 8; i++) begin
      b = 8'h40 + 8'(i);
      expect_beat({3'b000, b});
    end
    expect_beat(11'h600);
    for (int i = 0; i < 12; i++) cyc(1, 1, 0, 8'h40 + 8'(i));
    cyc(0, 0, 0, 8'h00);
    repeat (4) cyc(0, 0, 0, 8'h00);
    chk("ovf_once", ovf_cnt - ovf_base, 1);
    chk("stall_head", {rx_lp.valid, rx_lp.sop, rx_lp.data}, {22'h0, 2'b11, 8'h40});
    rx_lp.ready = 1'b1;
    drain("drain_ovf");
    expect_beat(11'h177); expect_beat(11'h288);
    cyc(1, 1, 0, 8'h77); cyc(1, 1, 0, 8'h88); cyc(0, 0, 0, 8'h00);
    drain("drain_after_ovf");

    // Reset during byte 2 of 5 with RxActive held high.
    cyc(1, 1, 0, 8'h11);
    rst_n = 1'b0;
    cyc(1, 1, 0, 8'h22);
    chk_zero("reset_mid_packet");
    cyc(1, 1, 0, 8'h33);
    rst_n = 1'b1;
    cyc(1, 1, 0, 8'h44); cyc(1, 1, 0, 8'h55); cyc(0, 0, 0, 8'h00);
    chk("dropped_after_reset", {31'h0, rx_lp.valid}, 0);
    expect_beat(11'h199); expect_beat(11'h2E7);
    cyc(1, 1, 0, 8'h99); cyc(1, 1, 0, 8'hE7); cyc(0, 0, 0, 8'h00);
    drain("drain_after_reset");

    chk("ovf_total", ovf_cnt, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
